// File: rtl/shadow_latch_bank_pkg.sv
// Shared constants for the shadow latch bank: operating modes and default geometry.
package shadow_latch_bank_pkg;
  localparam int unsigned MODE_BUFFERED = 0;
  localparam int unsigned MODE_DIRECT   = 1;
  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_CHANNELS  = 4;
endpackage

// File: rtl/shadow_latch_bank_latch_channel.sv
// One channel of the bank: shadow word, output word, pending and sticky overrun flags.
module latch_channel
  import shadow_latch_bank_pkg::*;
#(
  parameter int unsigned       WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  RST_VAL = '0,
  parameter int unsigned       MODE    = MODE_BUFFERED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             commit,
  output logic [WIDTH-1:0] d_out,
  output logic             pending,
  output logic             overrun
);

  if (MODE == MODE_DIRECT) begin : g_direct
    logic unused_commit;
    assign unused_commit = commit;
    assign pending = 1'b0;
    assign overrun = 1'b0;

    always_ff @(posedge clk) begin
      if (rst) begin
        d_out <= RST_VAL;
      end else if (load) begin
        d_out <= data;
      end
    end
  end else begin : g_buffered
    logic [WIDTH-1:0] shadow;

    always_ff @(posedge clk) begin
      if (rst) begin
        shadow  <= RST_VAL;
        d_out   <= RST_VAL;
        pending <= 1'b0;
        overrun <= 1'b0;
      end else begin
        if (load) begin
          shadow <= data;
        end
        // A commit drains the old shadow first, so a same-edge load is never an overrun.
        if (commit && pending) begin
          d_out   <= shadow;
          pending <= load;
          overrun <= 1'b0;
        end else if (load) begin
          pending <= 1'b1;
          if (pending) begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/shadow_latch_bank.sv
// Multi-channel double-buffered load latch with global atomic commit.
module shadow_latch_bank
  import shadow_latch_bank_pkg::*;
#(
  parameter int unsigned       WIDTH    = DEF_WIDTH,
  parameter int unsigned       CHANNELS = DEF_CHANNELS,
  parameter logic [WIDTH-1:0]  RST_VAL  = '0,
  parameter int unsigned       MODE     = MODE_BUFFERED
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          data,
  input  logic [CHANNELS-1:0]       load,
  input  logic                      commit,
  output logic [CHANNELS*WIDTH-1:0] d_out,
  output logic [CHANNELS-1:0]       pending,
  output logic [CHANNELS-1:0]       overrun,
  output logic                      commit_ack
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    latch_channel #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL),
      .MODE    (MODE)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .data    (data),
      .load    (load[i]),
      .commit  (commit),
      .d_out   (d_out[i*WIDTH +: WIDTH]),
      .pending (pending[i]),
      .overrun (overrun[i])
    );
  end

  // pending is constant zero in direct mode, so the ack stays low there without special-casing.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_ack <= 1'b0;
    end else begin
      commit_ack <= commit & (|pending);
    end
  end

endmodule

// File: tb/tb_shadow_latch_bank.sv
// Directed, table-driven bench for shadow_latch_bank (buffered default and a direct-mode instance).
module tb_shadow_latch_bank;
  import shadow_latch_bank_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Buffered DUT, defaults (WIDTH=8, CHANNELS=4)
  logic        rst, commit;
  logic [7:0]  data;
  logic [3:0]  load;
  logic [31:0] d_out;
  logic [3:0]  pending, overrun;
  logic        commit_ack;

  shadow_latch_bank #(
    .WIDTH    (8),
    .CHANNELS (4),
    .RST_VAL  (8'h00),
    .MODE     (MODE_BUFFERED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .load       (load),
    .commit     (commit),
    .d_out      (d_out),
    .pending    (pending),
    .overrun    (overrun),
    .commit_ack (commit_ack)
  );

  // Direct-mode DUT (WIDTH=16, CHANNELS=2)
  logic        rst2, commit2;
  logic [15:0] data2;
  logic [1:0]  load2;
  logic [31:0] d_out2;
  logic [1:0]  pending2, overrun2;
  logic        commit_ack2;

  shadow_latch_bank #(
    .WIDTH    (16),
    .CHANNELS (2),
    .RST_VAL  (16'h0000),
    .MODE     (MODE_DIRECT)
  ) dut_direct (
    .clk        (clk),
    .rst        (rst2),
    .data       (data2),
    .load       (load2),
    .commit     (commit2),
    .d_out      (d_out2),
    .pending    (pending2),
    .overrun    (overrun2),
    .commit_ack (commit_ack2)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [7:0]  data;
    logic [3:0]  load;
    logic        commit;
    logic [31:0] exp_d;
    logic [3:0]  exp_p;
    logic [3:0]  exp_o;
    logic        exp_ack;
  } vec_t;

  vec_t vecs[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic addv(input string name, input logic r, input logic [7:0] dt,
                      input logic [3:0] ld, input logic cm, input logic [31:0] ed,
                      input logic [3:0] ep, input logic [3:0] eo, input logic ea);
    vec_t v;
    v.name = name; v.rst = r; v.data = dt; v.load = ld; v.commit = cm;
    v.exp_d = ed; v.exp_p = ep; v.exp_o = eo; v.exp_ack = ea;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic r, input logic [15:0] dt, input logic [1:0] ld, input logic cm);
    rst2 = r; data2 = dt; load2 = ld; commit2 = cm;
  endtask

  initial begin
    rst = 1'b1; data = '0; load = '0; commit = 1'b0;
    rst2 = 1'b1; data2 = '0; load2 = '0; commit2 = 1'b0;

    //   name          rst data   load    cm  exp d_out      pend     ovr      ack
    addv("t1_rst0",    1, 8'hAA, 4'hF,   0, 32'h00000000, 4'b0000, 4'b0000, 0);
    addv("t1_rst1",    1, 8'hAA, 4'hF,   0, 32'h00000000, 4'b0000, 4'b0000, 0);
    addv("t2_load",    0, 8'h5A, 4'b0001,0, 32'h00000000, 4'b0001, 4'b0000, 0);
    addv("t2_hold",    0, 8'h00, 4'b0000,0, 32'h00000000, 4'b0001, 4'b0000, 0);
    addv("t2_commit",  0, 8'h00, 4'b0000,1, 32'h0000005A, 4'b0000, 4'b0000, 1);
    addv("t2_ackdrop", 0, 8'h00, 4'b0000,0, 32'h0000005A, 4'b0000, 4'b0000, 0);
    addv("t3_load11",  0, 8'h11, 4'b0100,0, 32'h0000005A, 4'b0100, 4'b0000, 0);
    addv("t3_load22",  0, 8'h22, 4'b0100,0, 32'h0000005A, 4'b0100, 4'b0100, 0);
    addv("t3_commit",  0, 8'h00, 4'b0000,1, 32'h0022005A, 4'b0000, 4'b0000, 1);
    addv("t4_load33",  0, 8'h33, 4'b0010,0, 32'h0022005A, 4'b0010, 4'b0000, 0);
    addv("t4_ld_cm",   0, 8'h44, 4'b0010,1, 32'h0022335A, 4'b0010, 4'b0000, 1);
    addv("t4_commit",  0, 8'h00, 4'b0000,1, 32'h0022445A, 4'b0000, 4'b0000, 1);
    addv("t4_idle",    0, 8'h00, 4'b0000,0, 32'h0022445A, 4'b0000, 4'b0000, 0);
    addv("t5_empty",   0, 8'h99, 4'b0000,1, 32'h0022445A, 4'b0000, 4'b0000, 0);
    addv("t5_loadall", 0, 8'hFF, 4'b1111,0, 32'h0022445A, 4'b1111, 4'b0000, 0);
    addv("t5_rst_cm",  1, 8'h00, 4'b0000,1, 32'h00000000, 4'b0000, 4'b0000, 0);
    addv("ov_load1",   0, 8'h01, 4'b0001,0, 32'h00000000, 4'b0001, 4'b0000, 0);
    addv("ov_load2",   0, 8'h02, 4'b0001,0, 32'h00000000, 4'b0001, 4'b0001, 0);
    addv("ov_sticky",  0, 8'h00, 4'b0000,0, 32'h00000000, 4'b0001, 4'b0001, 0);
    addv("ov_commit",  0, 8'h00, 4'b1000,1, 32'h00000002, 4'b1000, 4'b0000, 1);
    addv("ov_final",   0, 8'h00, 4'b0000,1, 32'h77000002, 4'b0000, 4'b0000, 1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; data = vecs[i].data; load = vecs[i].load; commit = vecs[i].commit;
      // ov_commit loads channel 3 with 8'h77 alongside the commit
      if (vecs[i].name == "ov_commit") data = 8'h77;
      step();
      chk({vecs[i].name, ".d_out"},   d_out,              vecs[i].exp_d);
      chk({vecs[i].name, ".pending"}, {28'h0, pending},   {28'h0, vecs[i].exp_p});
      chk({vecs[i].name, ".overrun"}, {28'h0, overrun},   {28'h0, vecs[i].exp_o});
      chk({vecs[i].name, ".ack"},     {31'h0, commit_ack},{31'h0, vecs[i].exp_ack});
    end
    rst = 1'b0; load = '0; commit = 1'b0;

    // Direct mode: one-edge load-to-output, commit ignored, shadow state tied off.
    drive2(1'b1, 16'h0000, 2'b00, 1'b0);
    step();
    chk("t6_rst.d_out", d_out2, 32'h0000_0000);
    drive2(1'b0, 16'hBEEF, 2'b10, 1'b0);
    step();
    chk("t6_load.d_out", d_out2, 32'hBEEF_0000);
    drive2(1'b0, 16'h0000, 2'b00, 1'b1);
    step();
    chk("t6_commit.d_out", d_out2, 32'hBEEF_0000);
    chk("t6_commit.pending", {30'h0, pending2}, 32'h0);
    drive2(1'b0, 16'h0000, 2'b00, 1'b0);
    step();
    chk("t6_commit.ack", {31'h0, commit_ack2}, 32'h0);
    drive2(1'b0, 16'h1234, 2'b01, 1'b1);
    step();
    chk("t6_load0.d_out", d_out2, 32'hBEEF_1234);
    chk("t6_load0.overrun", {30'h0, overrun2}, 32'h0);
    drive2(1'b0, 16'h0F0F, 2'b11, 1'b0);
    step();
    chk("t6_loadboth.d_out", d_out2, 32'h0F0F_0F0F);
    drive2(1'b0, 16'h0000, 2'b00, 1'b0);
    step();
    chk("t6_hold.d_out", d_out2, 32'h0F0F_0F0F);
    chk("t6_hold.ack", {31'h0, commit_ack2}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
